trap_ctrl: RTL
==============

# trap_ctrl

Parametrised pipeline control and machine-mode trap sequencer for the core. It generates per-stage stall and kill masks, takes exceptions reported at the mem stage and enabled interrupts from CLINT/PLIC, handles `mret`, and drives the CSR update strobes and the fetch redirect PC. Generalised over pipeline depth and number of local interrupt lines, and supports vectored mode.

## Interface
Parameters:
- `STAGES`, 5: number of pipeline stages; index 0 = pc/if, `STAGES-1` = mem.
- `NLOCAL`, 4: local interrupt lines; cause codes 16..16+NLOCAL-1, with NLOCAL ≤ 16.
- `REDIR_STAGE`, 3: stage resolving branches (ex).
- `RESET_ADDR`, 32'h0000_0000: fetch address after reset.

Ports (all widths 32 unless noted):
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `hold_req_i` in STAGES: stall request from each stage.
- `redirect_i` in 1: ex branch mispredict; `redirect_pc_i` in 32: its target.
- `mem_valid_i` in 1: the mem stage holds a real instruction.
- `mem_inst_i`, `mem_inst_addr_i` in 32: the mem-stage instruction and its PC.
- `mem_badaddr_i` in 32: load/store effective address.
- `exception_i` in 7: `{misaligned_load, misaligned_store, illegal, misaligned_inst, ebreak, ecall, mret}`.
- `irq_ext_i`, `irq_sw_i`, `irq_timer_i` in 1, and `irq_local_i` in NLOCAL: level pending lines.
- `mstatus_mie_i` in 1, `mie_i` in 32, `mtvec_i` in 32, `mepc_i` in 32: from csr.
- `hold_o` out STAGES: stall mask; `flush_o` out STAGES: kill mask; `new_pc_o` out 32 and `new_pc_valid_o` out 1: fetch redirect.
- `set_cause_o` out 1, `cause_o` out 32: mcause write; bit 31 = interrupt.
- `set_mepc_o` out 1, `mepc_o` out 32; `set_mtval_o` out 1, `mtval_o` out 32.
- `mie_clear_o` out 1, `mie_set_o` out 1: mstatus.MIE update.

## Operation
- States: RESET, RUN, TRAP, MRET. `rst` forces RESET. Every other state moves to RUN on the next cycle, except that RUN moves to TRAP or MRET on a decision.
- RESET: `flush_o` = all ones, `new_pc_o` = RESET_ADDR, `new_pc_valid_o` = 1. All CSR strobes are 0, and `cause_o`, `mepc_o`, `mtval_o` are 0.
- Interrupt pending, per line: line AND its `mie_i` bit. The bits are 11 (ext), 3 (sw), 7 (timer), and 16+i (local i). An interrupt is taken only if `mstatus_mie_i` is set.
- Interrupt priority: ext (cause 11), then sw (3), then timer (7), then local lowest index first.
- Exception priority: misaligned_inst (0, mtval = PC), then illegal (2, mtval = instruction), then ebreak (3, mtval = PC), then ecall (11, mtval 0, `set_mtval_o` = 0), then misaligned_store (6, mtval = `mem_badaddr_i`), then misaligned_load (4, mtval = `mem_badaddr_i`).
- Decision is made in RUN only when `mem_valid_i` = 1. Order: exception, then interrupt, then mret, else none.
  - Exception or interrupt: latch cause, mtval and mepc = `mem_inst_addr_i`, then go to TRAP.
  - mret: go to MRET.
- TRAP, one cycle:
  - `flush_o` = all ones and `new_pc_valid_o` = 1.
  - `new_pc_o` = `{mtvec[31:2],2'b00}` + (mode==1 && interrupt ? 4×code : 0). Modes 2 and 3 behave as direct.
  - `set_cause_o` = `set_mepc_o` = `mie_clear_o` = 1. `set_mtval_o` = 1 except for ecall and interrupts.
- MRET, one cycle: `flush_o` = all ones, `new_pc_o` = `mepc_i`, `new_pc_valid_o` = 1, `mie_set_o` = 1.
- RUN without a decision:
  - `hold_o[k]` = OR of `hold_req_i[STAGES-1:k]`.
  - If `redirect_i` is set and `hold_req_i[STAGES-1:REDIR_STAGE]` is clear: `flush_o[REDIR_STAGE-1:0]` = ones, `new_pc_o` = `redirect_pc_i`, `new_pc_valid_o` = 1.
  - Otherwise `flush_o` = 0 and `new_pc_valid_o` = 0.
- In TRAP/MRET, `hold_o` = 0, and `redirect_i`, `exception_i` and irqs are ignored. They belong to killed instructions.

## Timing
- Decision in cycle t; strobes, flush and redirect in t+1; RUN again at t+2. Trap latency is 1 cycle.
- CSR outputs (`cause_o`, `mepc_o`, `mtval_o`) are registered and stable from t+1 until the next decision.
- Exception together with an interrupt: the exception is taken. The interrupt stays pending (level) and is taken at the next valid mem instruction. The same applies to mret together with an interrupt: the interrupt wins, and mepc = the mret PC.
- A decision in the same cycle as `redirect_i`: the redirect applies in t and is overridden by the flush in t+1.
- `rst` asserted in TRAP/MRET: the strobes drop the next cycle, with no partial CSR update.

## Structure
- Package `trap_pkg` holds:
  - the state encoding (one-hot, 4 bits);
  - the exception bit positions of `exception_i`;
  - the cause codes;
  - the mtvec mode constants.
- Submodule `irq_arbiter` is a pure priority encoder. It takes the pending vector with `mie`/`mstatus` gating and outputs valid and a 5-bit code.

## Test plan
- Reset: `rst` high for 2 cycles, then low → one cycle with `new_pc_o` = RESET_ADDR, flush all ones; then RUN with all outputs 0.
- Illegal instruction at PC 0x100, inst 0xFFFF_FFFF, mtvec 0x8000_0001 → t+1: `cause_o` 2, mepc 0x100, mtval 0xFFFF_FFFF, `new_pc_o` 0x8000_0000.
- Timer and ext interrupts pending, mie bits 7 and 11 set, MIE = 1, vectored mtvec 0x8000_0001 → cause 0x8000_000B, `new_pc_o` 0x8000_002C. Timer taken after ext is dropped.
- Ecall together with local irq 2 → cause 11, `set_mtval_o` 0. Next valid instruction → cause 0x8000_0012.
- mret with `mepc_i` 0x204 → `new_pc_o` 0x204, `mie_set_o` 1 for exactly one cycle.
- `hold_req_i` = 5'b01000, `redirect_i` = 1 with target 0x40 → `hold_o` 01111, no redirect. After the hold drops → `flush_o` 00111, `new_pc_o` 0x40.

Source files
------------

// File: rtl/trap_pkg.sv
// trap_pkg: state encoding, exception bit positions, cause codes and mtvec modes for trap_ctrl.
package trap_pkg;
    typedef enum logic [3:0] {
        S_RESET = 4'b0001,
        S_RUN   = 4'b0010,
        S_TRAP  = 4'b0100,
        S_MRET  = 4'b1000
    } state_t;
    localparam int EXC_MRET      = 0;
    localparam int EXC_ECALL     = 1;
    localparam int EXC_EBREAK    = 2;
    localparam int EXC_MIS_INST  = 3;
    localparam int EXC_ILLEGAL   = 4;
    localparam int EXC_MIS_STORE = 5;
    localparam int EXC_MIS_LOAD  = 6;
    localparam logic [4:0] CAUSE_MIS_INST   = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL    = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
    localparam logic [4:0] CAUSE_MIS_LOAD   = 5'd4;
    localparam logic [4:0] CAUSE_MIS_STORE  = 5'd6;
    localparam logic [4:0] CAUSE_ECALL      = 5'd11;
    localparam logic [4:0] IRQ_SW           = 5'd3;
    localparam logic [4:0] IRQ_TIMER        = 5'd7;
    localparam logic [4:0] IRQ_EXT          = 5'd11;
    localparam int         IRQ_LOCAL_BASE   = 16;
    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;
endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: CSR-side bundle between the trap sequencer (master) and the csr file (slave).
interface trap_ctrl_if;
    logic        mstatus_mie_i;
    logic [31:0] mie_i, mtvec_i, mepc_i;
    logic        set_cause_o, set_mepc_o, set_mtval_o, mie_clear_o, mie_set_o;
    logic [31:0] cause_o, mepc_o, mtval_o;
    modport master (
        input  mstatus_mie_i, mie_i, mtvec_i, mepc_i,
        output set_cause_o, cause_o, set_mepc_o, mepc_o, set_mtval_o, mtval_o, mie_clear_o, mie_set_o
    );
    modport slave (
        output mstatus_mie_i, mie_i, mtvec_i, mepc_i,
        input  set_cause_o, cause_o, set_mepc_o, mepc_o, set_mtval_o, mtval_o, mie_clear_o, mie_set_o
    );
endinterface

// File: rtl/trap_ctrl_irq_arbiter.sv
// irq_arbiter: fixed-priority interrupt encoder (ext, sw, timer, then local lowest index) gated by mie/mstatus.MIE.
module irq_arbiter import trap_pkg::*; #(
    parameter int NLOCAL = 4
) (
    input  logic              irq_ext,
    input  logic              irq_sw,
    input  logic              irq_timer,
    input  logic [NLOCAL-1:0] irq_local,
    input  logic              mstatus_mie,
    input  logic [31:0]       mie,
    output logic              valid,
    output logic [4:0]        code
);
    logic pend;
    logic unused_mie;
    assign unused_mie = ^mie;
    // Later assignments override earlier ones, so the highest priority is written last.
    always_comb begin
        pend = 1'b0;
        code = '0;
        for (int i = NLOCAL - 1; i >= 0; i--)
            if (irq_local[i] && mie[IRQ_LOCAL_BASE + i]) begin
                pend = 1'b1;
                code = 5'(IRQ_LOCAL_BASE + i);
            end
        if (irq_timer && mie[IRQ_TIMER]) begin
            pend = 1'b1;
            code = IRQ_TIMER;
        end
        if (irq_sw && mie[IRQ_SW]) begin
            pend = 1'b1;
            code = IRQ_SW;
        end
        if (irq_ext && mie[IRQ_EXT]) begin
            pend = 1'b1;
            code = IRQ_EXT;
        end
    end
    assign valid = pend && mstatus_mie;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: pipeline stall/kill mask generation and machine-mode trap/mret sequencer.
module trap_ctrl import trap_pkg::*; #(
    parameter int          STAGES      = 5,
    parameter int          NLOCAL      = 4,
    parameter int          REDIR_STAGE = 3,
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] hold_req_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    input  logic              mem_valid_i,
    input  logic [31:0]       mem_inst_i,
    input  logic [31:0]       mem_inst_addr_i,
    input  logic [31:0]       mem_badaddr_i,
    input  logic [6:0]        exception_i,
    input  logic              irq_ext_i,
    input  logic              irq_sw_i,
    input  logic              irq_timer_i,
    input  logic [NLOCAL-1:0] irq_local_i,
    output logic [STAGES-1:0] hold_o,
    output logic [STAGES-1:0] flush_o,
    output logic [31:0]       new_pc_o,
    output logic              new_pc_valid_o,
    trap_ctrl_if.master       csr
);
    state_t            state, state_d;
    logic [31:0]       cause_q, mepc_q, mtval_q, trap_pc;
    logic              mtval_en_q, irq_valid, exc, exc_tval_en, take_trap, take_mret;
    logic [4:0]        irq_code, exc_code;
    logic [31:0]       exc_tval;
    logic [STAGES-1:0] hold_v;
    irq_arbiter #(.NLOCAL(NLOCAL)) u_irq (
        .irq_ext(irq_ext_i),
        .irq_sw(irq_sw_i),
        .irq_timer(irq_timer_i),
        .irq_local(irq_local_i),
        .mstatus_mie(csr.mstatus_mie_i),
        .mie(csr.mie_i),
        .valid(irq_valid),
        .code(irq_code)
    );
    always_comb begin
        exc = |exception_i[EXC_MIS_LOAD:EXC_ECALL];
        exc_code = exception_i[EXC_MIS_INST] ? CAUSE_MIS_INST :
                   exception_i[EXC_ILLEGAL]  ? CAUSE_ILLEGAL :
                   exception_i[EXC_EBREAK]   ? CAUSE_BREAKPOINT :
                   exception_i[EXC_ECALL]    ? CAUSE_ECALL :
                   exception_i[EXC_MIS_STORE] ? CAUSE_MIS_STORE : CAUSE_MIS_LOAD;
        exc_tval = exception_i[EXC_MIS_INST] ? mem_inst_addr_i :
                   exception_i[EXC_ILLEGAL]  ? mem_inst_i :
                   exception_i[EXC_EBREAK]   ? mem_inst_addr_i :
                   exception_i[EXC_ECALL]    ? 32'h0 : mem_badaddr_i;
        exc_tval_en = exception_i[EXC_MIS_INST] || exception_i[EXC_ILLEGAL] ||
                      exception_i[EXC_EBREAK] || !exception_i[EXC_ECALL];
        take_trap = state == S_RUN && mem_valid_i && (exc || irq_valid);
        take_mret = state == S_RUN && mem_valid_i && !exc && !irq_valid && exception_i[EXC_MRET];
        state_d = take_trap ? S_TRAP : take_mret ? S_MRET : S_RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RESET;
            cause_q    <= '0;
            mepc_q     <= '0;
            mtval_q    <= '0;
            mtval_en_q <= 1'b0;
        end else begin
            state <= state_d;
            if (take_trap) begin
                cause_q    <= {!exc, 26'b0, exc ? exc_code : irq_code};
                mepc_q     <= mem_inst_addr_i;
                mtval_q    <= exc ? exc_tval : 32'h0;
                mtval_en_q <= exc && exc_tval_en;
            end
        end
    end
    // A stage is held whenever it or any later stage requests a stall.
    always_comb begin
        hold_v = '0;
        for (int k = 0; k < STAGES; k++) hold_v[k] = |(hold_req_i >> k);
    end
    assign trap_pc = {csr.mtvec_i[31:2], 2'b00} +
                     ((csr.mtvec_i[1:0] == MTVEC_VECTORED && cause_q[31]) ? {25'b0, cause_q[4:0], 2'b00} : 32'h0);
    always_comb begin
        hold_o         = '0;
        flush_o        = '0;
        new_pc_o       = '0;
        new_pc_valid_o = 1'b0;
        if (state == S_RUN) begin
            hold_o = hold_v;
            if (redirect_i && !hold_v[REDIR_STAGE]) begin
                flush_o        = STAGES'((1 << REDIR_STAGE) - 1);
                new_pc_o       = redirect_pc_i;
                new_pc_valid_o = 1'b1;
            end
        end else begin
            flush_o        = '1;
            new_pc_valid_o = 1'b1;
            new_pc_o       = state == S_RESET ? RESET_ADDR : state == S_MRET ? csr.mepc_i : trap_pc;
        end
    end
    assign csr.set_cause_o = state == S_TRAP;
    assign csr.set_mepc_o  = state == S_TRAP;
    assign csr.mie_clear_o = state == S_TRAP;
    assign csr.set_mtval_o = state == S_TRAP && mtval_en_q;
    assign csr.mie_set_o   = state == S_MRET;
    assign csr.cause_o     = cause_q;
    assign csr.mepc_o      = mepc_q;
    assign csr.mtval_o     = mtval_q;
endmodule
